// File: rtl/lut_layer_pipe.sv
// lut_layer_pipe: N_NEURONS runtime-loadable truth-table neurons evaluated in parallel behind a
// two-stage valid/ready pipeline, with a table-write port that only fires on an empty pipeline.
module lut_layer_pipe #(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  parameter int NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [NW-1:0]                 cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_err
);

  localparam int DEPTH = 32'd1 << IN_BITS;

  logic                          s1_valid_r;
  logic [N_NEURONS*IN_BITS-1:0]  s1_data_r;
  logic                          out_valid_r;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_r;
  logic                          cfg_err_r;

  logic                          s2_en_s;
  logic                          s1_adv_s;
  logic                          in_ready_s;
  logic                          cfg_ready_s;
  logic                          in_fire_s;
  logic                          cfg_fire_s;
  logic                          cfg_in_range_s;
  logic [31:0]                   cfg_idx_s;
  logic [N_NEURONS*OUT_BITS-1:0] lookup_s;

  // Stage advance and handshake conditions for the data path and the config port.
  always_comb begin
    s2_en_s        = !out_valid_r || out_ready;
    s1_adv_s       = s1_valid_r && s2_en_s;
    in_ready_s     = !cfg_valid && (!s1_valid_r || s1_adv_s);
    cfg_ready_s    = !s1_valid_r && !out_valid_r;
    in_fire_s      = in_valid && in_ready_s;
    cfg_fire_s     = cfg_valid && cfg_ready_s;
    cfg_idx_s      = 32'(cfg_neuron);
    cfg_in_range_s = cfg_idx_s < 32'(N_NEURONS);
  end

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    logic [OUT_BITS-1:0] tbl_r [DEPTH];

    // Table write port; contents survive reset so a reload is never forced.
    always_ff @(posedge clk) begin
      if (cfg_fire_s && (cfg_idx_s == 32'(n))) begin
        tbl_r[cfg_addr] <= cfg_data;
      end
    end

    assign lookup_s[n*OUT_BITS +: OUT_BITS] = tbl_r[s1_data_r[n*IN_BITS +: IN_BITS]];
  end

  // Pipeline stages S1 (input word) and S2 (lookup result) plus the sticky config error.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      cfg_err_r   <= 1'b0;
    end else begin
      if (in_fire_s) begin
        s1_valid_r <= 1'b1;
        s1_data_r  <= in_data;
      end else if (s1_adv_s) begin
        s1_valid_r <= 1'b0;
      end
      if (s2_en_s) begin
        out_valid_r <= s1_valid_r;
      end
      // Bubbles leave the previous result in place rather than loading garbage.
      if (s2_en_s && s1_valid_r) begin
        out_data_r <= lookup_s;
      end
      if (cfg_fire_s && !cfg_in_range_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign cfg_ready = cfg_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Self-checking bench for lut_layer_pipe: one main instance (4,8,1) plus a parameter sweep,
// all checked against a table-level model with an expected-output queue.
`timescale 1ns/1ps
module tb_lut_layer_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [1:0]   sel;
  logic         in_valid_g, cfg_valid_g, out_ready_g;
  logic [639:0] in_data_g;
  logic [5:0]   cfg_neuron_g;
  logic [9:0]   cfg_addr_g;
  logic [3:0]   cfg_data_g;

  logic iv[4], cv[4], orr[4], ir[4], cr[4], ov[4], ce[4];
  logic [3:0]   od0;
  logic [0:0]   od1;
  logic [31:0]  od2;
  logic [255:0] od3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      iv[2'(i)]  = in_valid_g && (sel == 2'(i));
      cv[2'(i)]  = cfg_valid_g && (sel == 2'(i));
      orr[2'(i)] = (sel == 2'(i)) ? out_ready_g : 1'b1;
    end
  end

  lut_layer_pipe #(.N_NEURONS(4), .IN_BITS(8), .OUT_BITS(1), .NW(3)) u_main (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data_g[31:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0), .cfg_valid(cv[0]), .cfg_ready(cr[0]),
    .cfg_neuron(cfg_neuron_g[2:0]), .cfg_addr(cfg_addr_g[7:0]), .cfg_data(cfg_data_g[0:0]), .cfg_err(ce[0]));

  lut_layer_pipe #(.N_NEURONS(1), .IN_BITS(1), .OUT_BITS(1), .NW(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data_g[0:0]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1), .cfg_valid(cv[1]), .cfg_ready(cr[1]),
    .cfg_neuron(cfg_neuron_g[0:0]), .cfg_addr(cfg_addr_g[0:0]), .cfg_data(cfg_data_g[0:0]), .cfg_err(ce[1]));

  lut_layer_pipe #(.N_NEURONS(16), .IN_BITS(6), .OUT_BITS(2), .NW(4)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data_g[95:0]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2), .cfg_valid(cv[2]), .cfg_ready(cr[2]),
    .cfg_neuron(cfg_neuron_g[3:0]), .cfg_addr(cfg_addr_g[5:0]), .cfg_data(cfg_data_g[1:0]), .cfg_err(ce[2]));

  lut_layer_pipe #(.N_NEURONS(64), .IN_BITS(10), .OUT_BITS(4), .NW(6)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(in_data_g),
    .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od3), .cfg_valid(cv[3]), .cfg_ready(cr[3]),
    .cfg_neuron(cfg_neuron_g), .cfg_addr(cfg_addr_g), .cfg_data(cfg_data_g), .cfg_err(ce[3]));

  logic         cur_ir, cur_cr, cur_ov, cur_ce, cur_iv, cur_cv, cur_or;
  logic [255:0] cur_od;

  always_comb begin
    cur_ir = ir[sel];
    cur_cr = cr[sel];
    cur_ov = ov[sel];
    cur_ce = ce[sel];
    cur_iv = iv[sel];
    cur_cv = cv[sel];
    cur_or = orr[sel];
    case (sel)
      2'd0:    cur_od = 256'(od0);
      2'd1:    cur_od = 256'(od1);
      2'd2:    cur_od = 256'(od2);
      default: cur_od = od3;
    endcase
  end

  function automatic int nn_of(input logic [1:0] s);
    case (s) 2'd0: return 4; 2'd1: return 1; 2'd2: return 16; default: return 64; endcase
  endfunction
  function automatic int ib_of(input logic [1:0] s);
    case (s) 2'd0: return 8; 2'd1: return 1; 2'd2: return 6; default: return 10; endcase
  endfunction
  function automatic int ob_of(input logic [1:0] s);
    case (s) 2'd0: return 1; 2'd1: return 1; 2'd2: return 2; default: return 4; endcase
  endfunction

  // Model: the tables themselves plus a queue of results owed downstream.
  logic [3:0]   m_tbl [64][1024];
  logic         err_m [4];
  logic [255:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int or_mode  = 0;

  task automatic checkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [255:0] model_word(input logic [639:0] d);
    logic [255:0] r;
    logic [639:0] t;
    int a;
    r = '0;
    for (int n = 0; n < nn_of(sel); n++) begin
      t = d >> (n * ib_of(sel));
      a = int'(t[9:0]) & ((1 << ib_of(sel)) - 1);
      r = r | (256'(m_tbl[6'(n)][10'(a)] & 4'((1 << ob_of(sel)) - 1)) << (n * ob_of(sel)));
    end
    return r;
  endfunction

  function automatic logic [639:0] rep4(input logic [7:0] a);
    return 640'({a, a, a, a});
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready_g = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready_g = 1'b1;
        1:       out_ready_g = ~out_ready_g;
        default: ;
      endcase
    end
  end

  // Compare process: sampled on the falling edge, mid-cycle.
  initial begin
    logic         stall_prev;
    logic [255:0] stall_data;
    int           a;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
        for (int i = 0; i < 4; i++) err_m[2'(i)] = 1'b0;
      end else begin
        check1("cfg_err", cur_ce, err_m[sel]);
        if (stall_prev) begin
          check1("stall_valid", cur_ov, 1'b1);
          checkw("stall_data", cur_od, stall_data);
        end
        if (cur_ov && cur_or) begin
          if (exp_q.size() == 0) check1("extra_output", cur_ov, 1'b0);
          else checkw("out_data", cur_od, exp_q.pop_front());
        end
        if (cur_iv && cur_ir) exp_q.push_back(model_word(in_data_g));
        if (cur_cv && cur_cr) begin
          if (int'(cfg_neuron_g) < nn_of(sel)) begin
            a = int'(cfg_addr_g) & ((1 << ib_of(sel)) - 1);
            m_tbl[cfg_neuron_g][10'(a)] = cfg_data_g & 4'((1 << ob_of(sel)) - 1);
          end else begin
            err_m[sel] = 1'b1;
          end
        end
        stall_prev = cur_ov && !cur_or;
        stall_data = cur_od;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int n, input int a, input int d);
    int k;
    cfg_valid_g = 1'b1; cfg_neuron_g = 6'(n); cfg_addr_g = 10'(a); cfg_data_g = 4'(d);
    k = 0;
    @(negedge clk);
    while (!cur_cr && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check1("cfg_timeout", cur_cr, 1'b1);
    @(posedge clk);
    #1;
    cfg_valid_g = 1'b0;
  endtask

  task automatic send_word(input logic [639:0] d);
    int k;
    in_valid_g = 1'b1; in_data_g = d;
    k = 0;
    @(negedge clk);
    while (!cur_ir && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check1("in_timeout", cur_ir, 1'b1);
    @(posedge clk);
    #1;
    in_valid_g = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || cur_ov) && k < 500) begin
      tick();
      k++;
    end
    checkw("drain_empty", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [639:0] words [6];
    logic [639:0] t;
    int c0, a;
    rst = 1'b1; sel = 2'd0; in_valid_g = 1'b0; cfg_valid_g = 1'b0;
    in_data_g = '0; cfg_neuron_g = '0; cfg_addr_g = '0; cfg_data_g = '0;
    for (int i = 0; i < 4; i++) err_m[2'(i)] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rst_out_valid", cur_ov, 1'b0);
    check1("rst_cfg_err", cur_ce, 1'b0);
    check1("rst_cfg_ready", cur_cr, 1'b1);
    check1("rst_in_ready", cur_ir, 1'b1);
    checkw("rst_out_data", cur_od, 256'd0);
    tick();

    // Load: table[n][a] = parity(a) ^ n[0].
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 256; i++)
        cfg_write(n, i, int'(^8'(i)) ^ (n & 1));
    checkw("pin_a00", model_word(rep4(8'h00)), 256'ha);
    checkw("pin_a01", model_word(rep4(8'h01)), 256'h5);
    checkw("pin_a96", model_word(rep4(8'h96)), 256'ha);
    checkw("pin_a80", model_word(rep4(8'h80)), 256'h5);

    // Two-cycle latency on an empty pipe.
    send_word(rep4(8'h01));
    @(negedge clk);
    check1("lat_t1_valid", cur_ov, 1'b0);
    tick();
    @(negedge clk);
    check1("lat_t2_valid", cur_ov, 1'b1);
    checkw("lat_t2_data", cur_od, 256'h5);
    tick();
    drain();

    // Full sweep of addresses at one word per cycle.
    c0 = cyc;
    for (int i = 0; i < 256; i++) send_word(rep4(8'(i)));
    checkw("throughput", 256'(cyc - c0), 256'd256);
    drain();

    // Backpressure on alternate cycles.
    or_mode = 1;
    for (int i = 0; i < 20; i++) send_word(640'($urandom()));
    or_mode = 0;
    drain();

    // Two words held with downstream stalled: input must block.
    or_mode = 2; out_ready_g = 1'b0;
    send_word(rep4(8'h10));
    send_word(rep4(8'h20));
    in_valid_g = 1'b1; in_data_g = rep4(8'h30);
    @(negedge clk);
    check1("bp_in_ready", cur_ir, 1'b0);
    check1("bp_out_valid", cur_ov, 1'b1);
    tick();
    @(negedge clk);
    check1("bp_in_ready_2", cur_ir, 1'b0);
    tick();
    in_valid_g = 1'b0; out_ready_g = 1'b1; or_mode = 0;
    drain();

    // Config priority over a stalled, full pipeline with a third word waiting.
    or_mode = 2; out_ready_g = 1'b0;
    send_word(rep4(8'h11));
    send_word(rep4(8'h11));
    in_valid_g = 1'b1; in_data_g = rep4(8'h11);
    fork
      cfg_write(2, 8'h11, 1);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check1("prio_cfg_ready", cur_cr, 1'b0);
          check1("prio_in_ready", cur_ir, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready_g = 1'b1;
      end
    join
    @(negedge clk);
    check1("prio_accept_next", cur_ir, 1'b1);
    @(posedge clk);
    #1;
    in_valid_g = 1'b0; or_mode = 0;
    checkw("pin_prio", model_word(rep4(8'h11)), 256'he);
    drain();

    // Out-of-range neuron index.
    cfg_write(5, 0, 0);
    @(negedge clk);
    check1("oor_err", cur_ce, 1'b1);
    repeat (100) tick();
    @(negedge clk);
    check1("oor_err_100", cur_ce, 1'b1);
    tick();
    send_word(rep4(8'h00));
    send_word(rep4(8'h01));
    drain();

    // Reset with both stages full.
    or_mode = 2; out_ready_g = 1'b0;
    send_word(rep4(8'h02));
    send_word(rep4(8'h03));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check1("rstmid_out_valid", cur_ov, 1'b0);
    check1("rstmid_cfg_err", cur_ce, 1'b0);
    check1("rstmid_in_ready", cur_ir, 1'b1);
    tick();
    out_ready_g = 1'b1; or_mode = 0;
    send_word(rep4(8'h03));
    send_word(rep4(8'h07));
    drain();

    // Parameter sweep with random tables covering the addresses used.
    for (int s = 1; s < 4; s++) begin
      sel = 2'(s);
      tick();
      for (int w = 0; w < 6; w++) begin
        for (int k = 0; k < 20; k++) words[3'(w)][k*32 +: 32] = $urandom();
        for (int n = 0; n < nn_of(sel); n++) begin
          t = words[3'(w)] >> (n * ib_of(sel));
          a = int'(t[9:0]) & ((1 << ib_of(sel)) - 1);
          cfg_write(n, a, int'($urandom_range(0, (1 << ob_of(sel)) - 1)));
        end
      end
      or_mode = 1;
      for (int w = 0; w < 6; w++) send_word(words[3'(w)]);
      or_mode = 0;
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
